// File: rtl/eth_tx_framer_if.sv
// Payload stream into eth_tx_framer: byte data with valid/ready/last handshake.
interface eth_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: payload stream -> GMII bytes (preamble, SFD, payload, FCS, IFG).
// Define ETH_TX_PAD_EN to zero-pad payloads shorter than 60 bytes before the FCS.
module eth_tx_framer #(
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic           clk125,
  input  logic           rst,
  eth_tx_framer_if.slave s,
  output logic [7:0]     gmii_txd,
  output logic           gmii_txen,
  output logic           busy,
  output logic           underrun
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_e;

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] len_q, len_d, len_inc;
  logic [31:0] crc_q, crc_d, fcs_word;
  logic        abort_q, abort_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        busy_q;
  logic        underrun_q, underrun_d;
  logic        pad_needed;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign len_inc = (len_q == '1) ? len_q : len_q + 11'd1;

`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_LEN = 11'd60;
  assign pad_needed = (len_inc < MIN_LEN);
`else
  assign pad_needed = 1'b0;
`endif

  // An aborted frame sends the raw CRC register, i.e. the complement of the correct FCS.
  assign fcs_word = abort_q ? crc_q : ~crc_q;

  assign s.s_ready = (state_q == SFD) || (state_q == DATA) || (state_q == DRAIN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    crc_d      = crc_q;
    abort_d    = abort_q;
    txd_d      = '0;
    txen_d     = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s.s_valid) begin
          state_d = PRE;
          cnt_d   = '0;
          len_d   = '0;
          crc_d   = '1;
          abort_d = 1'b0;
          txd_d   = 8'h55;
          txen_d  = 1'b1;
        end
      end
      PRE: begin
        txen_d = 1'b1;
        if (cnt_q == 8'd6) begin
          txd_d   = 8'hD5;
          state_d = SFD;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + 8'd1;
        end
      end
      SFD, DATA: begin
        txen_d = 1'b1;
        if (s.s_valid) begin
          txd_d   = s.s_data;
          crc_d   = crc_byte(crc_q, s.s_data);
          len_d   = len_inc;
          state_d = DATA;
          if (s.s_last) begin
            state_d = pad_needed ? PAD : FCS;
            cnt_d   = '0;
          end
        end else begin
          // Empty beat: first FCS byte goes out now, so FCS resumes at index 1.
          abort_d    = 1'b1;
          underrun_d = 1'b1;
          txd_d      = crc_q[7:0];
          state_d    = FCS;
          cnt_d      = 8'd1;
        end
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        txen_d = 1'b1;
        crc_d  = crc_byte(crc_q, 8'h00);
        len_d  = len_inc;
        if (!pad_needed) begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
`endif
      FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == 8'd3) begin
          state_d = abort_q ? DRAIN : IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (s.s_valid && s.s_last) begin
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      crc_q      <= '1;
      abort_q    <= 1'b0;
      txd_q      <= '0;
      txen_q     <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      abort_q    <= abort_d;
      txd_q      <= txd_d;
      txen_q     <= txen_d;
      busy_q     <= (state_d != IDLE);
      underrun_q <= underrun_d;
    end
  end

  assign gmii_txd  = txd_q;
  assign gmii_txen = txen_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;
endmodule
